// File: rtl/hf_conf_sequencer_if.sv
// ARM-facing SPI lines plus the configuration outputs of hf_conf_sequencer.
interface hf_conf_sequencer_if;
  logic       spck;
  logic       mosi;
  logic       ncs;
  logic       miso;
  logic [7:0] conf_word;
  logic [2:0] major_mode;
  logic       switching;
  logic       cmd_err;

  modport master (
    output spck, mosi, ncs,
    input  miso, conf_word, major_mode, switching, cmd_err
  );

  modport slave (
    input  spck, mosi, ncs,
    output miso, conf_word, major_mode, switching, cmd_err
  );
endinterface

// File: rtl/hf_conf_sequencer.sv
// Clocked SPI configuration receiver with a glitch-free major-mode guard interval.
// Optional readback of the active word on miso when HF_CONF_READBACK_EN is defined.
module hf_conf_sequencer #(
  parameter int unsigned GUARD_CYCLES    = 64,
  parameter logic [3:0]  CMD_SET_CONFREG = 4'b0001
) (
  input  logic               ck_1356meg,
  input  logic               reset,
  hf_conf_sequencer_if.slave spi
);

  localparam logic [7:0] GuardLoad = 8'(GUARD_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StGuard} state_e;

  // [0] first stage, [1] synchronised value, [2] previous synchronised value
  logic [2:0]  spck_q;
  logic [2:0]  ncs_q;
  logic [1:0]  mosi_q;
  logic [15:0] shift_q;
  logic [4:0]  bit_cnt_q;

  state_e      state_q;
  logic [7:0]  conf_q;
  logic [7:0]  pending_q;
  logic [7:0]  guard_q;
  logic [2:0]  major_q;
  logic        switching_q;
  logic        cmd_err_q;

  logic spck_rise, ncs_fall, ncs_rise, ncs_s;
  logic frame_ok, frame_err;
  logic [7:0] new_word;

  assign ncs_s     = ncs_q[1];
  assign spck_rise = spck_q[1] & ~spck_q[2];
  assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
  assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
  assign new_word  = shift_q[7:0];
  assign frame_ok  = ncs_rise && (bit_cnt_q == 5'd16) && (shift_q[15:12] == CMD_SET_CONFREG);
  assign frame_err = ncs_rise && !frame_ok;

  // ncs flops reset high so an idle-high chip select does not look like a frame end.
  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      spck_q <= 3'b000;
      ncs_q  <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      spck_q <= {spck_q[1:0], spi.spck};
      ncs_q  <= {ncs_q[1:0], spi.ncs};
      mosi_q <= {mosi_q[0], spi.mosi};
    end
  end

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      shift_q   <= 16'h0000;
      bit_cnt_q <= 5'd0;
    end else if (ncs_fall) begin
      bit_cnt_q <= 5'd0;
    end else if (spck_rise && !ncs_s) begin
      shift_q   <= {shift_q[14:0], mosi_q[1]};
      bit_cnt_q <= (bit_cnt_q == 5'd31) ? bit_cnt_q : bit_cnt_q + 5'd1;
    end
  end

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      conf_q      <= 8'hE0;
      pending_q   <= 8'h00;
      guard_q     <= 8'd0;
      major_q     <= 3'b111;
      switching_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      cmd_err_q <= frame_err;
      case (state_q)
        StIdle: begin
          if (frame_ok) begin
            if (new_word[7:5] == conf_q[7:5]) begin
              conf_q <= new_word;
            end else begin
              pending_q   <= new_word;
              guard_q     <= GuardLoad;
              major_q     <= 3'b111;
              switching_q <= 1'b1;
              state_q     <= StGuard;
            end
          end
        end
        StGuard: begin
          // A fresh frame restarts the whole guard, even if it returns to the old mode.
          if (frame_ok) begin
            pending_q <= new_word;
            guard_q   <= GuardLoad;
          end else if (guard_q == 8'd0) begin
            conf_q      <= pending_q;
            major_q     <= pending_q[7:5];
            switching_q <= 1'b0;
            state_q     <= StIdle;
          end else begin
            guard_q <= guard_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign spi.conf_word  = conf_q;
  assign spi.major_mode = major_q;
  assign spi.switching  = switching_q;
  assign spi.cmd_err    = cmd_err_q;

`ifdef HF_CONF_READBACK_EN
  logic        spck_fall;
  logic [15:0] rb_load;
  logic [15:0] rb_q;
  logic        miso_q;

  assign spck_fall = ~spck_q[1] & spck_q[2];
  assign rb_load   = {4'b0001, 4'b0000, conf_q};

  // MSB is presented at frame start so it is valid before the first spck rise.
  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      rb_q   <= 16'h0000;
      miso_q <= 1'b0;
    end else if (ncs_fall) begin
      miso_q <= rb_load[15];
      rb_q   <= {rb_load[14:0], 1'b0};
    end else if (ncs_s) begin
      miso_q <= 1'b0;
    end else if (spck_fall) begin
      miso_q <= rb_q[15];
      rb_q   <= {rb_q[14:0], 1'b0};
    end
  end

  assign spi.miso = miso_q;
`else
  assign spi.miso = 1'b0;
`endif

endmodule

// File: tb/tb_hf_conf_sequencer.sv
// Directed bench for hf_conf_sequencer: vector table plus guard-restart, reset and readback cases.
module tb_hf_conf_sequencer;

  localparam int G1 = 64;
  localparam int G2 = 100;

  logic clk = 1'b0;
  logic rst;
  logic spck, mosi, ncs;

  hf_conf_sequencer_if if1 ();
  hf_conf_sequencer_if if2 ();

  assign if1.spck = spck;
  assign if1.mosi = mosi;
  assign if1.ncs  = ncs;
  assign if2.spck = spck;
  assign if2.mosi = mosi;
  assign if2.ncs  = ncs;

  always #5 clk = ~clk;

  hf_conf_sequencer #(.GUARD_CYCLES(G1)) dut1 (
    .ck_1356meg (clk),
    .reset      (rst),
    .spi        (if1.slave)
  );

  // Longer guard so a second frame can land inside a running guard.
  hf_conf_sequencer #(.GUARD_CYCLES(G2)) dut2 (
    .ck_1356meg (clk),
    .reset      (rst),
    .spi        (if2.slave)
  );

  int cyc = 0;
  int sw1 = 0, sw2 = 0, err1 = 0, viol1 = 0, miso_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if1.switching) sw1 <= sw1 + 1;
    if (if2.switching) sw2 <= sw2 + 1;
    if (if1.cmd_err) err1 <= err1 + 1;
    if (if1.miso) miso_hi <= miso_hi + 1;
    if (if1.switching && if1.major_mode != 3'b111) viol1 <= viol1 + 1;
    else if (!if1.switching && if1.major_mode != if1.conf_word[7:5]) viol1 <= viol1 + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits, input int h,
                            output int t_rise, output logic [31:0] rb);
    rb = 32'h0;
    step(1);
    ncs = 1'b0;
    step(h);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = data[i];
      spck = 1'b0;
      step(h);
      rb   = {rb[30:0], if1.miso};
      spck = 1'b1;
      step(h);
    end
    spck = 1'b0;
    step(h);
    ncs    = 1'b1;
    t_rise = cyc;
    step(4);
  endtask

  typedef struct {
    logic [31:0] data;
    int          nbits;
    logic [7:0]  conf;
    logic [2:0]  major;
    int          errs;
    int          guard;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int s_sw, s_err, s_viol, s_sw2, t1, t2;
    logic [31:0] rbw;

    vecs[0] = '{32'h0000_1020, 16, 8'h20, 3'b001, 0, G1};
    vecs[1] = '{32'h0000_1021, 16, 8'h21, 3'b001, 0, 0};
    vecs[2] = '{32'h0000_0821, 15, 8'h21, 3'b001, 1, 0};
    vecs[3] = '{32'h0001_1040, 17, 8'h21, 3'b001, 1, 0};
    vecs[4] = '{32'h0000_2040, 16, 8'h21, 3'b001, 1, 0};
    vecs[5] = '{32'h0000_10E5, 16, 8'hE5, 3'b111, 0, G1};
    vecs[6] = '{32'h0000_10E0, 16, 8'hE0, 3'b111, 0, 0};
    vecs[7] = '{32'h0000_1000, 16, 8'h00, 3'b000, 0, G1};

    rst  = 1'b1;
    spck = 1'b0;
    mosi = 1'b0;
    ncs  = 1'b1;
    step(3);
    chk("rst_conf", int'(if1.conf_word), 'hE0);
    chk("rst_major", int'(if1.major_mode), 3'b111);
    chk("rst_switching", int'(if1.switching), 0);
    chk("rst_cmd_err", int'(if1.cmd_err), 0);
    chk("rst_miso", int'(if1.miso), 0);
    rst = 1'b0;
    step(5);
    settle();
    chk("post_rst_major", int'(if1.major_mode), 3'b111);
    chk("post_rst_errs", err1, 0);

    for (int i = 0; i < 8; i++) begin
      s_sw   = sw1;
      s_err  = err1;
      s_viol = viol1;
      send_frame(vecs[i].data, vecs[i].nbits, 2, t1, rbw);
      step(G2 + 20);
      settle();
      chk($sformatf("v%0d_conf", i), int'(if1.conf_word), int'(vecs[i].conf));
      chk($sformatf("v%0d_major", i), int'(if1.major_mode), int'(vecs[i].major));
      chk($sformatf("v%0d_switching", i), int'(if1.switching), 0);
      chk($sformatf("v%0d_errs", i), err1 - s_err, vecs[i].errs);
      chk($sformatf("v%0d_guard_len", i), sw1 - s_sw, vecs[i].guard);
      chk($sformatf("v%0d_mode_rule", i), viol1 - s_viol, 0);
    end

    // Second frame arrives while dut2 is still guarding the first one.
    s_sw2 = sw2;
    s_err = err1;
    send_frame(32'h0000_1040, 16, 2, t1, rbw);
    send_frame(32'h0000_1060, 16, 2, t2, rbw);
    settle();
    chk("restart_in_guard", int'(if2.switching), 1);
    chk("restart_old_conf", int'(if2.conf_word), 'h00);
    chk("restart_major_off", int'(if2.major_mode), 3'b111);
    step(G2 + 40);
    settle();
    chk("restart_guard_len", sw2 - s_sw2, (t2 - t1) + G2);
    chk("restart_conf2", int'(if2.conf_word), 'h60);
    chk("restart_major2", int'(if2.major_mode), 3'b011);
    chk("restart_conf1", int'(if1.conf_word), 'h60);
    chk("restart_errs", err1 - s_err, 0);

`ifdef HF_CONF_READBACK_EN
    send_frame(32'h0000_1021, 16, 2, t1, rbw);
    step(G2 + 20);
    settle();
    chk("rb_setup_conf", int'(if1.conf_word), 'h21);
    send_frame(32'h0000_1021, 16, 4, t1, rbw);
    chk("rb_word", int'(rbw[15:0]), 'h1021);
    settle();
    chk("rb_idle_miso", int'(if1.miso), 0);
`else
    chk("miso_tied_low", miso_hi, 0);
`endif

    // Reset lands part-way through a guard.
    s_err = err1;
    send_frame(32'h0000_1080, 16, 2, t1, rbw);
    step(9);
    chk("pre_rst_guarding", int'(if1.switching), 1);
    rst = 1'b1;
    #1;
    s_sw = sw1;
    chk("midrst_conf", int'(if1.conf_word), 'hE0);
    chk("midrst_major", int'(if1.major_mode), 3'b111);
    chk("midrst_switching", int'(if1.switching), 0);
    chk("midrst_cmd_err", int'(if1.cmd_err), 0);
    chk("midrst_miso", int'(if1.miso), 0);
    step(3);
    rst = 1'b0;
    step(G2 + 50);
    settle();
    chk("after_rst_conf", int'(if1.conf_word), 'hE0);
    chk("after_rst_major", int'(if1.major_mode), 3'b111);
    chk("after_rst_switching", int'(if1.switching), 0);
    chk("after_rst_guard", sw1 - s_sw, 0);
    chk("after_rst_errs", err1 - s_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
